// File: rtl/matrix_entry_ctrl.sv
// matrix_entry_ctrl
//   Cursor-driven entry of an N x N matrix of W-bit elements, followed by a
//   valid/ready hand-off of the whole matrix to a consumer and a wait for
//   the consumer's acknowledge before entry resumes.
//
// Ports
//   i_clk, i_reset         clock, synchronous active-high reset
//   i_up/down/left/right   single-cycle cursor move pulses
//   i_enter, i_din         write i_din at the cursor
//   i_clear_all            zero all cells and written flags
//   i_start                request hand-off of the matrix
//   i_ack                  consumer done, return to entry
//   i_mat_ready            consumer ready for the matrix
//   o_mat_flat             packed matrix, element (r,c) at [(r*N+c)*W +: W]
//   o_mat_valid            matrix offered (ISSUE state)
//   o_cur_row, o_cur_col   cursor position
//   o_cur_val              registered element under the cursor
//   o_filled_cnt           distinct cells written since last clear
//   o_all_filled           every cell written
//   o_q_enter/issue/wait   one-hot state indicators
module matrix_entry_ctrl #(
  parameter int N            = 3,
  parameter int W            = 4,
  parameter int REQUIRE_FULL = 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_up,
  input  logic             i_down,
  input  logic             i_left,
  input  logic             i_right,
  input  logic             i_enter,
  input  logic             i_clear_all,
  input  logic             i_start,
  input  logic             i_ack,
  input  logic [W-1:0]     i_din,
  input  logic             i_mat_ready,
  output logic [N*N*W-1:0] o_mat_flat,
  output logic             o_mat_valid,
  output logic [2:0]       o_cur_row,
  output logic [2:0]       o_cur_col,
  output logic [W-1:0]     o_cur_val,
  output logic [6:0]       o_filled_cnt,
  output logic             o_all_filled,
  output logic             o_q_enter,
  output logic             o_q_issue,
  output logic             o_q_wait
);

  localparam int CELLS = N * N;

  typedef enum logic [1:0] {S_ENTER, S_ISSUE, S_WAIT} state_t;

  state_t               r_state, w_state_nxt;
  logic [W-1:0]         r_cells [CELLS];
  logic [W-1:0]         w_cells_nxt [CELLS];
  logic [CELLS-1:0]     r_written, w_written_nxt;
  logic [6:0]           r_cnt, w_cnt_nxt;
  logic [2:0]           r_row, r_col, w_row_nxt, w_col_nxt;
  logic [W-1:0]         r_cur_val, w_cur_val_nxt;
  logic                 w_in_enter;
  logic                 w_vmove;
  logic                 w_all_filled;
  int                   w_idx, w_idx_nxt;

  function automatic logic [2:0] f_inc(input logic [2:0] v);
    return (v == 3'(N - 1)) ? 3'd0 : v + 3'd1;
  endfunction

  function automatic logic [2:0] f_dec(input logic [2:0] v);
    return (v == 3'd0) ? 3'(N - 1) : v - 3'd1;
  endfunction

  assign w_in_enter   = (r_state == S_ENTER);
  assign w_all_filled = (r_cnt == 7'(CELLS));
  assign w_vmove      = i_up ^ i_down;
  assign w_idx        = int'(r_row) * N + int'(r_col);
  assign w_idx_nxt    = int'(w_row_nxt) * N + int'(w_col_nxt);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_ENTER;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic; All_filled is the pre-write value, so a Start that
  // arrives with the final Enter is ignored.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_ENTER: if (i_start && (REQUIRE_FULL == 0 || w_all_filled)) w_state_nxt = S_ISSUE;
      S_ISSUE: if (i_mat_ready) w_state_nxt = S_WAIT;
      S_WAIT:  if (i_ack) w_state_nxt = S_ENTER;
      default: w_state_nxt = S_ENTER;
    endcase
  end

  // Cursor: vertical move applied first; a horizontal wrap carries into the
  // row only when no vertical move is happening in the same cycle.
  always_comb begin
    w_row_nxt = r_row;
    w_col_nxt = r_col;
    if (w_in_enter) begin
      if (i_down && !i_up)      w_row_nxt = f_inc(r_row);
      else if (i_up && !i_down) w_row_nxt = f_dec(r_row);
      if (i_right && !i_left) begin
        w_col_nxt = f_inc(r_col);
        if (r_col == 3'(N - 1) && !w_vmove) w_row_nxt = f_inc(r_row);
      end else if (i_left && !i_right) begin
        w_col_nxt = f_dec(r_col);
        if (r_col == 3'd0 && !w_vmove) w_row_nxt = f_dec(r_row);
      end
    end
  end

  // Cell store: writes use the pre-move cursor; clear beats enter.
  always_comb begin
    w_written_nxt = r_written;
    w_cnt_nxt     = r_cnt;
    for (int i = 0; i < CELLS; i++) w_cells_nxt[i] = r_cells[i];
    if (w_in_enter) begin
      if (i_clear_all) begin
        w_written_nxt = '0;
        w_cnt_nxt     = '0;
        for (int i = 0; i < CELLS; i++) w_cells_nxt[i] = '0;
      end else if (i_enter) begin
        for (int i = 0; i < CELLS; i++) begin
          if (i == w_idx) begin
            w_cells_nxt[i]   = i_din;
            w_written_nxt[i] = 1'b1;
            if (!r_written[i]) w_cnt_nxt = r_cnt + 7'd1;
          end
        end
      end
    end
    w_cur_val_nxt = '0;
    for (int i = 0; i < CELLS; i++) begin
      if (i == w_idx_nxt) w_cur_val_nxt = w_cells_nxt[i];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_written <= '0;
      r_cnt     <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_cur_val <= '0;
      for (int i = 0; i < CELLS; i++) r_cells[i] <= '0;
    end else begin
      r_written <= w_written_nxt;
      r_cnt     <= w_cnt_nxt;
      r_row     <= w_row_nxt;
      r_col     <= w_col_nxt;
      r_cur_val <= w_cur_val_nxt;
      for (int i = 0; i < CELLS; i++) r_cells[i] <= w_cells_nxt[i];
    end
  end

  for (genvar g = 0; g < CELLS; g++) begin : g_flat
    assign o_mat_flat[g*W +: W] = r_cells[g];
  end

  assign o_mat_valid  = (r_state == S_ISSUE);
  assign o_cur_row    = r_row;
  assign o_cur_col    = r_col;
  assign o_cur_val    = r_cur_val;
  assign o_filled_cnt = r_cnt;
  assign o_all_filled = w_all_filled;
  assign o_q_enter    = (r_state == S_ENTER);
  assign o_q_issue    = (r_state == S_ISSUE);
  assign o_q_wait     = (r_state == S_WAIT);

endmodule

// File: tb/tb_matrix_entry_ctrl.sv
module tb_matrix_entry_ctrl;

  localparam int N = 3;
  localparam int W = 4;

  logic             clk = 1'b0;
  logic             rst, up, down, left, right, enter, clr, start, ack, mat_ready;
  logic [W-1:0]     din;
  logic [N*N*W-1:0] mat_flat;
  logic             mat_valid, all_filled, q_enter, q_issue, q_wait;
  logic [2:0]       cur_row, cur_col;
  logic [W-1:0]     cur_val;
  logic [6:0]       filled_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic [N*N*W-1:0] exp_q [$];

  always #5 clk = ~clk;

  matrix_entry_ctrl #(.N(N), .W(W), .REQUIRE_FULL(1)) dut (
    .i_clk(clk), .i_reset(rst), .i_up(up), .i_down(down), .i_left(left),
    .i_right(right), .i_enter(enter), .i_clear_all(clr), .i_start(start),
    .i_ack(ack), .i_din(din), .i_mat_ready(mat_ready),
    .o_mat_flat(mat_flat), .o_mat_valid(mat_valid), .o_cur_row(cur_row),
    .o_cur_col(cur_col), .o_cur_val(cur_val), .o_filled_cnt(filled_cnt),
    .o_all_filled(all_filled), .o_q_enter(q_enter), .o_q_issue(q_issue),
    .o_q_wait(q_wait)
  );

  // Monitor: every transfer (valid && ready on the coming edge) pops the
  // expected matrix from the scoreboard.
  always @(negedge clk) begin
    if (!rst && mat_valid && mat_ready) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL xfer_unexpected: got %h, no transfer expected", mat_flat);
      end else begin
        logic [N*N*W-1:0] e;
        e = exp_q.pop_front();
        if (mat_flat !== e) begin
          n_fail++;
          $display("FAIL xfer_data: got %h, expected %h", mat_flat, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    {up, down, left, right, enter, clr, start, ack} = '0;
  endtask

  task automatic cursor(input string name, input int r, input int c);
    chk({name, "_row"}, 64'(cur_row), 64'(r));
    chk({name, "_col"}, 64'(cur_col), 64'(c));
  endtask

  initial begin
    rst = 1'b1; mat_ready = 1'b0; din = '0;
    idle();
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_q_enter", 64'(q_enter), 64'd1);
    chk("rst_valid", 64'(mat_valid), 64'd0);
    chk("rst_flat", 64'(mat_flat), 64'd0);
    chk("rst_cnt", 64'(filled_cnt), 64'd0);
    chk("rst_curval", 64'(cur_val), 64'd0);
    cursor("rst", 0, 0);

    // Cursor moves
    for (int i = 0; i < 3; i++) begin right = 1; cyc(); idle(); end
    cursor("right3", 1, 0);
    left = 1; cyc(); idle();
    cursor("left1", 0, 2);
    up = 1; cyc(); idle();
    cursor("up1", 2, 2);
    up = 1; down = 1; cyc(); idle();
    cursor("updown", 2, 2);
    down = 1; right = 1; cyc(); idle();
    cursor("down_right_nocarry", 0, 0);

    // Fill 8 cells row-major, writing with a simultaneous Right
    for (int k = 1; k <= 8; k++) begin
      din = 4'(k); enter = 1; right = 1; cyc(); idle();
    end
    chk("cnt8", 64'(filled_cnt), 64'd8);
    start = 1; cyc(); idle();
    chk("start_not_full", 64'(q_enter), 64'd1);
    chk("start_not_full_valid", 64'(mat_valid), 64'd0);
    // 9th write with Start: write lands, Start sees pre-write All_filled
    din = 4'd9; enter = 1; right = 1; start = 1; cyc(); idle();
    chk("start_with_last_write", 64'(q_enter), 64'd1);
    chk("cnt9", 64'(filled_cnt), 64'd9);
    chk("all_filled", 64'(all_filled), 64'd1);
    cursor("wrap_end", 0, 0);
    chk("curval_00", 64'(cur_val), 64'd1);

    // Issue with ready held high
    mat_ready = 1;
    exp_q.push_back(36'h987654321);
    start = 1; cyc(); idle();
    chk("issue_state", 64'(q_issue), 64'd1);
    chk("issue_valid", 64'(mat_valid), 64'd1);
    cyc();
    chk("wait_state", 64'(q_wait), 64'd1);
    chk("wait_valid", 64'(mat_valid), 64'd0);
    // Ignored inputs in WAIT
    din = 4'hF; enter = 1; clr = 1; right = 1; start = 1; cyc(); idle();
    chk("wait_ignore_flat", 64'(mat_flat), 64'h987654321);
    cursor("wait_ignore", 0, 0);
    chk("wait_hold", 64'(q_wait), 64'd1);
    ack = 1; cyc(); idle();
    chk("ack_enter", 64'(q_enter), 64'd1);
    chk("ack_flat", 64'(mat_flat), 64'h987654321);
    ack = 1; cyc(); idle();
    chk("ack_in_enter", 64'(q_enter), 64'd1);

    // Back-pressure in ISSUE
    mat_ready = 0;
    start = 1; cyc(); idle();
    for (int i = 0; i < 5; i++) begin
      din = 4'hF; enter = 1; clr = (i == 2); cyc(); idle();
      chk("bp_valid", 64'(mat_valid), 64'd1);
      chk("bp_flat", 64'(mat_flat), 64'h987654321);
    end
    exp_q.push_back(36'h987654321);
    mat_ready = 1; cyc();
    chk("bp_wait", 64'(q_wait), 64'd1);
    ack = 1; cyc(); idle();
    mat_ready = 0;

    // Rewrite and clear
    down = 1; right = 1; cyc(); idle();
    cursor("to11", 1, 1);
    clr = 1; cyc(); idle();
    chk("clr_cnt", 64'(filled_cnt), 64'd0);
    chk("clr_flat", 64'(mat_flat), 64'd0);
    cursor("clr_keep", 1, 1);
    din = 4'h5; enter = 1; cyc(); idle();
    chk("wr11_cnt", 64'(filled_cnt), 64'd1);
    chk("wr11_curval", 64'(cur_val), 64'h5);
    din = 4'hA; enter = 1; cyc(); idle();
    chk("rewr11_cnt", 64'(filled_cnt), 64'd1);
    chk("rewr11_curval", 64'(cur_val), 64'hA);
    chk("rewr11_flat", 64'(mat_flat), 64'h0000A0000);
    din = 4'h7; enter = 1; clr = 1; cyc(); idle();
    chk("clr_enter_flat", 64'(mat_flat), 64'd0);
    chk("clr_enter_cnt", 64'(filled_cnt), 64'd0);
    chk("clr_enter_curval", 64'(cur_val), 64'd0);

    // Refill, issue, then reset in WAIT
    left = 1; up = 1; cyc(); idle();
    cursor("back00", 0, 0);
    for (int k = 0; k < 9; k++) begin
      din = 4'(15 - k); enter = 1; right = 1; cyc(); idle();
    end
    mat_ready = 1;
    exp_q.push_back(36'h789ABCDEF);
    start = 1; cyc(); idle();
    cyc();
    chk("wait2", 64'(q_wait), 64'd1);
    right = 1; rst = 1; cyc(); rst = 0; idle();
    mat_ready = 0;
    chk("rst_wait_enter", 64'(q_enter), 64'd1);
    chk("rst_wait_flat", 64'(mat_flat), 64'd0);
    chk("rst_wait_cnt", 64'(filled_cnt), 64'd0);
    chk("rst_wait_filled", 64'(all_filled), 64'd0);
    cursor("rst_wait", 0, 0);

    cyc();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_entry_ctrl.md
MATRIX_ENTRY_CTRL -- requirements
Module: matrix_entry_ctrl

Interface
REQ-001 Parameter N, default 3: matrix dimension (rows = columns), legal range 2..8.
REQ-002 Parameter W, default 4: element width in bits, legal range 1..16.
REQ-003 Parameter REQUIRE_FULL, default 1: when 1, Start is accepted only once every cell has been written.
REQ-004 Clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 Reset  in  1  synchronous, active-high reset.
REQ-006 Up, Down, Left, Right  in  1 each  single-cycle cursor-move pulses.
REQ-007 Enter  in  1  single-cycle pulse: write Din at the cursor.
REQ-008 ClearAll  in  1  single-cycle pulse: zero the matrix and all written flags.
REQ-009 Start  in  1  request to issue the matrix to the consumer.
REQ-010 Ack  in  1  consumer result acknowledged; return to entry.
REQ-011 Din  in  W  element value to write.
REQ-012 Mat_ready  in  1  consumer ready to accept the matrix.
REQ-013 Mat_flat  out  N*N*W  packed matrix; element (r,c) at bits [(r*N+c)*W +: W].
REQ-014 Mat_valid  out  1  matrix offered to the consumer.
REQ-015 Cur_row, Cur_col  out  3 each  cursor position.
REQ-016 Cur_val  out  W  registered element under the cursor.
REQ-017 Filled_cnt  out  7  number of distinct cells written since the last clear.
REQ-018 All_filled  out  1  Filled_cnt == N*N.
REQ-019 q_Enter, q_Issue, q_Wait  out  1 each  one-hot state indicators.

Function
REQ-020 The FSM SHALL have exactly three states: ENTER, ISSUE and WAIT, with the matching q_* output high.
REQ-021 In ENTER, Enter SHALL write Din to cell (Cur_row,Cur_col) and set that cell's written flag on the same edge.
REQ-022 Filled_cnt SHALL increment only when the target cell's written flag was previously 0; a rewrite SHALL leave the count unchanged.
REQ-023 Right SHALL move to column+1; column N-1 SHALL wrap to 0 with row+1; cell (N-1,N-1) SHALL wrap to (0,0).
REQ-024 Left SHALL perform the inverse of Right, with (0,0) wrapping to (N-1,N-1).
REQ-025 Down SHALL move to row+1 and Up to row-1, wrapping modulo N, with the column unchanged.
REQ-026 If Up and Down are both asserted, or Left and Right are both asserted, that axis SHALL not move; a horizontal and a vertical move in the same cycle SHALL both apply, vertical first, and the horizontal move SHALL NOT carry into the row.
REQ-027 If Enter and a move are asserted together, the write SHALL use the pre-move cursor.
REQ-028 ClearAll in ENTER SHALL zero all cells, flags and Filled_cnt, leave the cursor unchanged, and take priority over a simultaneous Enter.
REQ-029 In ENTER, Start SHALL move the FSM to ISSUE if REQUIRE_FULL==0 or All_filled==1; otherwise it SHALL be ignored.
REQ-030 Start and Enter in the same cycle: the write SHALL complete, and All_filled SHALL be evaluated before the write.
REQ-031 Mat_valid SHALL be 1 exactly while in ISSUE.
REQ-032 A transfer SHALL occur on the edge where Mat_valid && Mat_ready, and the FSM SHALL then go to WAIT; with Mat_ready held high, Mat_valid SHALL last exactly one cycle.
REQ-033 In WAIT, Ack SHALL return the FSM to ENTER with the matrix contents and cursor retained.
REQ-034 Ack in ENTER or ISSUE SHALL be ignored.
REQ-035 In ISSUE and WAIT, Enter, ClearAll, moves and Start SHALL be ignored.
REQ-036 Mat_flat SHALL remain constant from ISSUE entry until the FSM returns to ENTER.
REQ-037 Cur_val SHALL reflect the cell under the cursor one cycle after any write or move.

Reset
REQ-038 On Reset, the FSM SHALL go to ENTER and the cursor to (0,0).
REQ-039 On Reset, all cells, flags, Filled_cnt, All_filled, Mat_valid and Cur_val SHALL be cleared to 0.
REQ-040 Reset SHALL take precedence over all other inputs, including during ISSUE or WAIT, and no transfer SHALL occur on the reset edge.

Verification
REQ-041 N=3, W=4: Right pulsed 3 times from (0,0) -> cursor (1,0); then Left once -> (0,2); then Up once -> (2,2).
REQ-042 Write 1..9 row-major, Start, Mat_ready=1 -> Mat_valid high 1 cycle, Mat_flat=36'h987654321, Filled_cnt=9, then q_Wait=1.
REQ-043 REQUIRE_FULL=1, 8 cells written, Start -> q_Enter stays 1, Mat_valid=0; write the 9th cell and Start -> q_Issue=1.
REQ-044 In ISSUE with Mat_ready=0 for 5 cycles, Enter with Din=F -> Mat_valid held high and Mat_flat unchanged; Mat_ready=1 -> transfer, then WAIT.
REQ-045 Rewrite cell (1,1) twice -> Filled_cnt +1 only; ClearAll+Enter in the same cycle -> all zero, Filled_cnt=0.
REQ-046 Reset asserted in WAIT -> next cycle q_Enter=1, Mat_flat=0, cursor (0,0), Filled_cnt=0.
